fifo_axis_reader: RTL and testbench

- Drains the read side of a show-ahead single-clock FIFO (rd/data/empty, data valid while empty low) and presents the words as an AXI4-Stream master.
- Registered 2-entry output buffer decouples FIFO pop from downstream tready; tlast generated from a programmable packet length.
- Sits between sc_fifo instances and stream consumers (DMA, video/packet sinks).

---
 rtl/fifo_axis_reader.sv | 122 ++++++++++++
 tb/tb_fifo_axis_reader.sv | 287 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fifo_axis_reader.sv
// Drains a show-ahead FIFO into an AXI4-Stream master through a 2-entry registered buffer; first word 1 cycle after fifo_empty_i falls, 1 word/cycle sustained.
// Stalls on m_tready_i low by withholding fifo_rd_o once both entries are full. Optional stats counters: FIFO_AXIS_READER_STATS_EN.
module fifo_axis_reader #(
    parameter int DATA_WIDTH = 8,
    parameter int LEN_WIDTH  = 16
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  enable_i,
    input  logic [LEN_WIDTH-1:0]  pkt_len_i,
    output logic                  fifo_rd_o,
    input  logic [DATA_WIDTH-1:0] fifo_data_i,
    input  logic                  fifo_empty_i,
    output logic                  m_tvalid_o,
    input  logic                  m_tready_i,
    output logic [DATA_WIDTH-1:0] m_tdata_o,
    output logic                  m_tlast_o
`ifdef FIFO_AXIS_READER_STATS_EN
    ,
    output logic [31:0]           word_cnt_o,
    output logic [31:0]           pkt_cnt_o
`endif
);

    logic [1:0]            count_q, count_d;
    logic [DATA_WIDTH-1:0] e0_dat_q, e0_dat_d, e1_dat_q, e1_dat_d;
    logic                  e0_last_q, e0_last_d, e1_last_q, e1_last_d;
    logic [LEN_WIDTH-1:0]  beat_q, beat_d, len_q, len_d, cur_len;
    logic                  pop, accept, new_last;

    always_comb begin
        pop      = !rst_i && enable_i && !fifo_empty_i && (count_q != 2'd2);
        accept   = (count_q != 2'd0) && m_tready_i;
        // Length is latched at the first pop of a packet; 0 wraps to the full counter range.
        cur_len  = (beat_q == '0) ? pkt_len_i : len_q;
        new_last = (beat_q == (cur_len - LEN_WIDTH'(1)));

        count_d   = count_q;
        e0_dat_d  = e0_dat_q;
        e0_last_d = e0_last_q;
        e1_dat_d  = e1_dat_q;
        e1_last_d = e1_last_q;
        beat_d    = beat_q;
        len_d     = len_q;

        if (pop) begin
            beat_d = new_last ? '0 : beat_q + LEN_WIDTH'(1);
            len_d  = cur_len;
        end

        case ({pop, accept})
            2'b10: begin
                count_d = count_q + 2'd1;
                if (count_q == 2'd0) begin
                    e0_dat_d  = fifo_data_i;
                    e0_last_d = new_last;
                end else begin
                    e1_dat_d  = fifo_data_i;
                    e1_last_d = new_last;
                end
            end
            2'b01: begin
                count_d = count_q - 2'd1;
                if (count_q == 2'd2) begin
                    e0_dat_d  = e1_dat_q;
                    e0_last_d = e1_last_q;
                end
            end
            2'b11: begin
                // Only reachable with one entry held: the new word replaces the departing head.
                e0_dat_d  = fifo_data_i;
                e0_last_d = new_last;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            count_q   <= 2'd0;
            e0_dat_q  <= '0;
            e0_last_q <= 1'b0;
            e1_dat_q  <= '0;
            e1_last_q <= 1'b0;
            beat_q    <= '0;
            len_q     <= '0;
        end else begin
            count_q   <= count_d;
            e0_dat_q  <= e0_dat_d;
            e0_last_q <= e0_last_d;
            e1_dat_q  <= e1_dat_d;
            e1_last_q <= e1_last_d;
            beat_q    <= beat_d;
            len_q     <= len_d;
        end
    end

    assign fifo_rd_o  = pop;
    assign m_tvalid_o = (count_q != 2'd0);
    assign m_tdata_o  = e0_dat_q;
    assign m_tlast_o  = e0_last_q;

`ifdef FIFO_AXIS_READER_STATS_EN
    logic [31:0] word_cnt_q, pkt_cnt_q;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            word_cnt_q <= 32'd0;
            pkt_cnt_q  <= 32'd0;
        end else if (accept) begin
            word_cnt_q <= word_cnt_q + 32'd1;
            if (e0_last_q) begin
                pkt_cnt_q <= pkt_cnt_q + 32'd1;
            end
        end
    end

    assign word_cnt_o = word_cnt_q;
    assign pkt_cnt_o  = pkt_cnt_q;
`endif

endmodule

// File: tb/tb_fifo_axis_reader.sv
// Bench for fifo_axis_reader: a behavioural show-ahead FIFO feeds a 16-bit-length DUT and a 2-bit-length
// twin that sees identical traffic, so the twin exercises the length-0 (full range) packet case.
module tb_fifo_axis_reader;

    logic        clk = 1'b0;
    logic        rst_i = 1'b1;
    logic        enable_i = 1'b0;
    logic [15:0] pkt_len = 16'd4;
    logic        fifo_rd, fifo_rd2;
    logic [7:0]  fifo_data;
    logic        fifo_empty;
    logic        m_tready = 1'b0;
    logic        m_tvalid, m_tlast, m_tvalid2, m_tlast2;
    logic [7:0]  m_tdata, m_tdata2;
`ifdef FIFO_AXIS_READER_STATS_EN
    logic [31:0] word_cnt, pkt_cnt, word_cnt2, pkt_cnt2;
`endif

    always #5 clk = ~clk;

    logic [7:0] mem [0:255];
    logic [7:0] rd_ptr = 8'd0;
    logic [7:0] wr_ptr = 8'd0;
    logic [7:0] pop_base = 8'd0;

    assign fifo_empty = (rd_ptr == wr_ptr);
    assign fifo_data  = mem[rd_ptr];

    always @(posedge clk) begin
        if (fifo_rd === 1'b1) rd_ptr <= rd_ptr + 8'd1;
    end

    fifo_axis_reader #(.DATA_WIDTH(8), .LEN_WIDTH(16)) u_dut (
        .clk_i(clk), .rst_i(rst_i), .enable_i(enable_i), .pkt_len_i(pkt_len),
        .fifo_rd_o(fifo_rd), .fifo_data_i(fifo_data), .fifo_empty_i(fifo_empty),
        .m_tvalid_o(m_tvalid), .m_tready_i(m_tready), .m_tdata_o(m_tdata), .m_tlast_o(m_tlast)
`ifdef FIFO_AXIS_READER_STATS_EN
        , .word_cnt_o(word_cnt), .pkt_cnt_o(pkt_cnt)
`endif
    );

    fifo_axis_reader #(.DATA_WIDTH(8), .LEN_WIDTH(2)) u_dut2 (
        .clk_i(clk), .rst_i(rst_i), .enable_i(enable_i), .pkt_len_i(pkt_len[1:0]),
        .fifo_rd_o(fifo_rd2), .fifo_data_i(fifo_data), .fifo_empty_i(fifo_empty),
        .m_tvalid_o(m_tvalid2), .m_tready_i(m_tready), .m_tdata_o(m_tdata2), .m_tlast_o(m_tlast2)
`ifdef FIFO_AXIS_READER_STATS_EN
        , .word_cnt_o(word_cnt2), .pkt_cnt_o(pkt_cnt2)
`endif
    );

    int errors = 0;
    int checks = 0;
    int viol = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic push(input logic [7:0] d);
        mem[wr_ptr] = d;
        wr_ptr = wr_ptr + 8'd1;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_i  = 1'b1;
        wr_ptr = rd_ptr;
        #1;
        chk("rst_tvalid", {31'd0, m_tvalid}, 32'd0);
        @(negedge clk);
        rst_i    = 1'b0;
        pop_base = rd_ptr;
    endtask

    logic [7:0] got_dat[$];
    logic       got_last[$];
    logic       got_last2[$];

    // Records each beat that will be accepted at the next rising edge.
    task automatic collect(input int n, input int sw_after, input logic [15:0] sw_len);
        int cyc = 0;
        got_dat.delete(); got_last.delete(); got_last2.delete();
        while (got_dat.size() < n && cyc < 100) begin
            @(negedge clk); #1;
            cyc++;
            if (fifo_rd && fifo_empty) viol++;
            if (fifo_rd !== fifo_rd2) viol++;
            if (m_tvalid && m_tready) begin
                got_dat.push_back(m_tdata);
                got_last.push_back(m_tlast);
                got_last2.push_back(m_tlast2);
                if (got_dat.size() == sw_after) pkt_len = sw_len;
            end
        end
        chk("collect_beats", got_dat.size(), n);
    endtask

    typedef struct {
        logic       rst;
        logic       push4;
        logic [7:0] base;
        logic       en;
        logic       rdy;
        logic       vld;
        logic [7:0] dat;
        logic       last;
        logic       rd;
        int         pops;
    } vec_t;

    function automatic vec_t row(logic rst, logic push4, logic [7:0] base, logic en, logic rdy,
                                 logic vld, logic [7:0] dat, logic last, logic rd, int pops);
        vec_t v;
        v = '{rst, push4, base, en, rdy, vld, dat, last, rd, pops};
        return v;
    endfunction

    vec_t tbl[18];

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        logic [7:0] exp_dat;
        logic       exp_l;
        logic       lasts_b[6];
        logic       lasts_c[8];
        int         rd_hits;

        // Packet of 4 streaming at full rate, then the same with 5 cycles of backpressure.
        tbl[0]  = row(1, 0, 8'h00, 1, 1, 0, 8'h00, 0, 0, 0);
        tbl[1]  = row(0, 1, 8'hA0, 1, 1, 0, 8'h00, 0, 1, 0);
        tbl[2]  = row(0, 0, 8'h00, 1, 1, 1, 8'hA0, 0, 1, 1);
        tbl[3]  = row(0, 0, 8'h00, 1, 1, 1, 8'hA1, 0, 1, 2);
        tbl[4]  = row(0, 0, 8'h00, 1, 1, 1, 8'hA2, 0, 1, 3);
        tbl[5]  = row(0, 0, 8'h00, 1, 1, 1, 8'hA3, 1, 0, 4);
        tbl[6]  = row(0, 0, 8'h00, 1, 1, 0, 8'h00, 0, 0, 4);
        tbl[7]  = row(1, 0, 8'h00, 1, 0, 0, 8'h00, 0, 0, 0);
        tbl[8]  = row(0, 1, 8'hB0, 1, 0, 0, 8'h00, 0, 1, 0);
        tbl[9]  = row(0, 0, 8'h00, 1, 0, 1, 8'hB0, 0, 1, 1);
        tbl[10] = row(0, 0, 8'h00, 1, 0, 1, 8'hB0, 0, 0, 2);
        tbl[11] = row(0, 0, 8'h00, 1, 0, 1, 8'hB0, 0, 0, 2);
        tbl[12] = row(0, 0, 8'h00, 1, 0, 1, 8'hB0, 0, 0, 2);
        tbl[13] = row(0, 0, 8'h00, 1, 1, 1, 8'hB0, 0, 0, 2);
        tbl[14] = row(0, 0, 8'h00, 1, 1, 1, 8'hB1, 0, 1, 2);
        tbl[15] = row(0, 0, 8'h00, 1, 1, 1, 8'hB2, 0, 1, 3);
        tbl[16] = row(0, 0, 8'h00, 1, 1, 1, 8'hB3, 1, 0, 4);
        tbl[17] = row(0, 0, 8'h00, 1, 1, 0, 8'h00, 0, 0, 4);

        pkt_len = 16'd4;
        for (int i = 0; i < 18; i++) begin
            @(negedge clk);
            rst_i = tbl[i].rst;
            if (tbl[i].rst) begin
                wr_ptr   = rd_ptr;
                pop_base = rd_ptr;
            end
            if (tbl[i].push4) begin
                for (int k = 0; k < 4; k++) push(tbl[i].base + 8'(k));
            end
            enable_i = tbl[i].en;
            m_tready = tbl[i].rdy;
            #1;
            chk($sformatf("v%0d_tvalid", i), {31'd0, m_tvalid}, {31'd0, tbl[i].vld});
            chk($sformatf("v%0d_fifo_rd", i), {31'd0, fifo_rd}, {31'd0, tbl[i].rd});
            chk($sformatf("v%0d_pops", i), {24'd0, 8'(rd_ptr - pop_base)}, 32'(tbl[i].pops));
            if (tbl[i].vld || tbl[i].rst) begin
                chk($sformatf("v%0d_tdata", i), {24'd0, m_tdata}, {24'd0, tbl[i].dat});
                chk($sformatf("v%0d_tlast", i), {31'd0, m_tlast}, {31'd0, tbl[i].last});
                chk($sformatf("v%0d_tlast_w2", i), {31'd0, m_tlast2}, {31'd0, tbl[i].last});
            end
        end

        // Length 1: every beat is the last of its packet.
        do_reset();
        pkt_len = 16'd1; enable_i = 1'b1; m_tready = 1'b1;
        for (int k = 0; k < 3; k++) push(8'hC0 + 8'(k));
        collect(3, -1, 16'd0);
        for (int k = 0; k < got_dat.size(); k++) begin
            chk($sformatf("len1_dat%0d", k), {24'd0, got_dat[k]}, {24'd0, 8'hC0 + 8'(k)});
            chk($sformatf("len1_last%0d", k), {31'd0, got_last[k]}, 32'd1);
        end

        // Length changed 3 -> 2 after the first beat: current packet keeps 3, next uses 2.
        do_reset();
        pkt_len = 16'd3;
        for (int k = 0; k < 6; k++) push(8'hD0 + 8'(k));
        collect(6, 1, 16'd2);
        lasts_b = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
        for (int k = 0; k < got_dat.size(); k++) begin
            chk($sformatf("lchg_dat%0d", k), {24'd0, got_dat[k]}, {24'd0, 8'hD0 + 8'(k)});
            chk($sformatf("lchg_last%0d", k), {31'd0, got_last[k]}, {31'd0, lasts_b[k]});
        end

        // pkt_len 4 is 0 for the 2-bit-length twin, giving tlast every 4th word there too.
        do_reset();
        pkt_len = 16'd4;
        for (int k = 0; k < 8; k++) push(8'h10 + 8'(k));
        collect(8, -1, 16'd0);
        lasts_c = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
        for (int k = 0; k < got_dat.size(); k++) begin
            chk($sformatf("len0_w2_last%0d", k), {31'd0, got_last2[k]}, {31'd0, lasts_c[k]});
            chk($sformatf("len4_last%0d", k), {31'd0, got_last[k]}, {31'd0, lasts_c[k]});
        end

        // enable_i low: the one buffered word still drains and no further pops occur.
        do_reset();
        enable_i = 1'b1; m_tready = 1'b0; pkt_len = 16'd4;
        for (int k = 0; k < 3; k++) push(8'h20 + 8'(k));
        #1;
        chk("en_rd_first", {31'd0, fifo_rd}, 32'd1);
        @(negedge clk);
        enable_i = 1'b0;
        #1;
        chk("en0_rd", {31'd0, fifo_rd}, 32'd0);
        chk("en0_tvalid_held", {31'd0, m_tvalid}, 32'd1);
        chk("en0_tdata", {24'd0, m_tdata}, 32'h20);
        m_tready = 1'b1;
        rd_hits = 0;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk); #1;
            if (fifo_rd) rd_hits++;
        end
        chk("en0_drained", {31'd0, m_tvalid}, 32'd0);
        chk("en0_rd_hits", 32'(rd_hits), 32'd0);
        chk("en0_pops", {24'd0, 8'(rd_ptr - pop_base)}, 32'd1);

        // Empty FIFO with enable high: no pop strobe ever.
        do_reset();
        enable_i = 1'b1;
        rd_hits = 0;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk); #1;
            if (fifo_rd) rd_hits++;
        end
        chk("empty_rd_hits", 32'(rd_hits), 32'd0);
        chk("empty_tvalid", {31'd0, m_tvalid}, 32'd0);

        // Reset while holding beat 2 of 4 with both entries full.
        do_reset();
        pkt_len = 16'd4; enable_i = 1'b1; m_tready = 1'b1;
        for (int k = 0; k < 6; k++) push(8'hE0 + 8'(k));
        @(negedge clk);
        @(negedge clk);
        m_tready = 1'b0;
        @(negedge clk); #1;
        chk("mid_tdata", {24'd0, m_tdata}, 32'hE1);
        chk("mid_rd_full", {31'd0, fifo_rd}, 32'd0);
        rst_i = 1'b1;
        #1;
        chk("mid_rst_tvalid", {31'd0, m_tvalid}, 32'd0);
        chk("mid_rst_tdata", {24'd0, m_tdata}, 32'd0);
        chk("mid_rst_tlast", {31'd0, m_tlast}, 32'd0);
`ifdef FIFO_AXIS_READER_STATS_EN
        chk("mid_rst_word_cnt", word_cnt, 32'd0);
        chk("mid_rst_pkt_cnt", pkt_cnt, 32'd0);
`endif
        @(negedge clk);
        rst_i = 1'b0;
        push(8'hE6);
        m_tready = 1'b1;
        collect(4, -1, 16'd0);
        for (int k = 0; k < got_dat.size(); k++) begin
            exp_dat = 8'hE3 + 8'(k);
            exp_l   = (k == 3);
            chk($sformatf("post_rst_dat%0d", k), {24'd0, got_dat[k]}, {24'd0, exp_dat});
            chk($sformatf("post_rst_last%0d", k), {31'd0, got_last[k]}, {31'd0, exp_l});
        end
        @(negedge clk); #1;
`ifdef FIFO_AXIS_READER_STATS_EN
        chk("stats_word_cnt", word_cnt, 32'd4);
        chk("stats_pkt_cnt", pkt_cnt, 32'd1);
`endif
        chk("rd_protocol_viol", 32'(viol), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
